// File: rtl/spi_slave_sync.sv
// -----------------------------------------------------------------------------
// spi_slave_sync
//   Mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit SPI slave that runs entirely on
//   the system clock. SCK, SS and MOSI are oversampled through synchronizers
//   and edge detectors. Received bytes come out as a parallel byte with a
//   one-cycle strobe. Transmit data goes through a single-entry holding
//   register with a ready/load handshake.
//
// Ports
//   sysClk_i    in   1  system clock (only clock in the block)
//   reset_i     in   1  synchronous, active-high reset
//   spiClk_i    in   1  SCK from master (async)
//   ss_i_n      in   1  slave select, active low (async)
//   mosi_i      in   1  serial data from master (async)
//   miso_o      out  1  serial data to master
//   tx_byte_i   in   8  byte to transmit next
//   tx_load_i   in   1  capture tx_byte_i when tx_ready_o=1
//   tx_ready_o  out  1  TX holding register empty
//   rx_byte_o   out  8  last completely received byte
//   rx_valid_o  out  1  one-cycle strobe, rx_byte_o updated
//   busy_o      out  1  frame active
//   abort_o     out  1  one-cycle strobe, SS deasserted mid-byte
//
// state   | meaning
// S_IDLE  | no frame; waiting for a synced SS falling edge
// S_SHIFT | frame active; sampling on SCK rise, shifting out on SCK fall
// -----------------------------------------------------------------------------
module spi_slave_sync #(
   parameter int          SYNC_STAGES = 2,
   parameter logic [7:0]  FILL_BYTE   = 8'h00
) (
   input  logic        sysClk_i,
   input  logic        reset_i,
   input  logic        spiClk_i,
   input  logic        ss_i_n,
   input  logic        mosi_i,
   output logic        miso_o,
   input  logic [7:0]  tx_byte_i,
   input  logic        tx_load_i,
   output logic        tx_ready_o,
   output logic [7:0]  rx_byte_o,
   output logic        rx_valid_o,
   output logic        busy_o,
   output logic        abort_o
);

   typedef enum logic {S_IDLE, S_SHIFT} state_t;

   localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);

   // synchronizers and edge history
   logic [SYNC_STAGES-1:0] sck_sync_q;
   logic [SYNC_STAGES-1:0] ss_sync_q;
   logic [SYNC_STAGES-1:0] mosi_sync_q;
   logic                   sck_hist_q;
   logic                   ss_hist_q;
   logic [SETTLE_W-1:0]    settle_q;
   logic                   armed_q;

   // FSM / datapath
   state_t      state_q;
   logic [2:0]  bit_cnt_q;
   logic [6:0]  rx_shift_q;
   logic [6:0]  tx_shift_q;      // bits still to send after the one on miso_o
   logic        tx_full_q;
   logic        tx_full_d;
   logic [7:0]  tx_hold_q;
   logic [7:0]  tx_hold_d;

   logic        sck_s;
   logic        ss_s;
   logic        mosi_s;
   logic        settled;
   logic        ss_fall;
   logic        ss_rise;
   logic        sck_rise;
   logic        sck_fall;
   logic        tx_take;
   logic [7:0]  tx_next_byte;

   // MOSI is taken from the last sync stage, the same point SCK edges are
   // detected at, so data and clock see identical delay.
   assign sck_s  = sck_sync_q[SYNC_STAGES-1];
   assign ss_s   = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

   // After reset the chains still hold idle values, not pin values. Edges are
   // ignored until the pin values have reached the history stage, and a frame
   // start additionally needs SS to have been seen high, so a reset inside a
   // frame never turns into a mid-byte join.
   assign settled  = (settle_q == '0);
   assign ss_fall  = settled & armed_q & ss_hist_q & ~ss_s;
   assign ss_rise  = settled & ~ss_hist_q & ss_s;
   assign sck_rise = settled & ~sck_hist_q & sck_s;
   assign sck_fall = settled & sck_hist_q & ~sck_s;

   assign tx_next_byte = tx_full_q ? tx_hold_q : FILL_BYTE;
   assign tx_take = ((state_q == S_IDLE) && ss_fall) ||
                    ((state_q == S_SHIFT) && !ss_rise && sck_fall && (bit_cnt_q == 3'd0));
   assign tx_ready_o = ~tx_full_q;

   always_ff @(posedge sysClk_i) begin
      if (reset_i) begin
         sck_sync_q  <= '0;
         ss_sync_q   <= '1;
         mosi_sync_q <= '0;
         sck_hist_q  <= 1'b0;
         ss_hist_q   <= 1'b1;
         settle_q    <= SETTLE_W'(SYNC_STAGES + 1);
         armed_q     <= 1'b0;
      end else begin
         sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spiClk_i};
         ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_i_n};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
         sck_hist_q  <= sck_s;
         ss_hist_q   <= ss_s;
         if (!settled)
            settle_q <= settle_q - SETTLE_W'(1);
         if (settled && ss_s)
            armed_q <= 1'b1;
      end
   end

   // A consume and a load in the same cycle: the consume sees the register
   // as it was (empty -> FILL_BYTE), the load then fills it.
   always_comb begin
      tx_full_d = tx_full_q;
      tx_hold_d = tx_hold_q;
      if (tx_take)
         tx_full_d = 1'b0;
      if (tx_load_i && !tx_full_q) begin
         tx_full_d = 1'b1;
         tx_hold_d = tx_byte_i;
      end
   end

   always_ff @(posedge sysClk_i) begin
      if (reset_i) begin
         tx_full_q <= 1'b0;
         tx_hold_q <= 8'h00;
      end else begin
         tx_full_q <= tx_full_d;
         tx_hold_q <= tx_hold_d;
      end
   end

   always_ff @(posedge sysClk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= 3'd0;
         rx_shift_q <= 7'd0;
         tx_shift_q <= 7'd0;
         miso_o     <= 1'b0;
         rx_byte_o  <= 8'h00;
         rx_valid_o <= 1'b0;
         busy_o     <= 1'b0;
         abort_o    <= 1'b0;
      end else begin
         rx_valid_o <= 1'b0;
         abort_o    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               busy_o <= 1'b0;
               miso_o <= 1'b0;
               if (ss_fall) begin
                  state_q    <= S_SHIFT;
                  busy_o     <= 1'b1;
                  bit_cnt_q  <= 3'd0;
                  rx_shift_q <= 7'd0;
                  miso_o     <= tx_next_byte[7];
                  tx_shift_q <= tx_next_byte[6:0];
               end
            end
            S_SHIFT: begin
               busy_o <= 1'b1;
               // SS release has priority over any SCK edge in the same cycle.
               if (ss_rise) begin
                  state_q   <= S_IDLE;
                  busy_o    <= 1'b0;
                  miso_o    <= 1'b0;
                  bit_cnt_q <= 3'd0;
                  if (bit_cnt_q != 3'd0)
                     abort_o <= 1'b1;
               end else if (sck_rise) begin
                  rx_shift_q <= {rx_shift_q[5:0], mosi_s};
                  bit_cnt_q  <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     rx_byte_o  <= {rx_shift_q, mosi_s};
                     rx_valid_o <= 1'b1;
                  end
               end else if (sck_fall) begin
                  if (bit_cnt_q == 3'd0) begin
                     miso_o     <= tx_next_byte[7];
                     tx_shift_q <= tx_next_byte[6:0];
                  end else begin
                     miso_o     <= tx_shift_q[6];
                     tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                  end
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_slave_sync.sv
// -----------------------------------------------------------------------------
// tb_spi_slave_sync
//   Drives spi_slave_sync as a mode-0 SPI master at SCK = sysClk/8 and checks
//   MISO bytes, received bytes, strobes and the TX handshake against a
//   byte-level model (holding register = full flag + value, one consume per
//   byte start).
// -----------------------------------------------------------------------------
module tb_spi_slave_sync;

   localparam logic [7:0] FILL = 8'h00;

   logic       sysClk_i = 1'b0;
   logic       reset_i;
   logic       spiClk_i;
   logic       ss_i_n;
   logic       mosi_i;
   logic       miso_o;
   logic [7:0] tx_byte_i;
   logic       tx_load_i;
   logic       tx_ready_o;
   logic [7:0] rx_byte_o;
   logic       rx_valid_o;
   logic       busy_o;
   logic       abort_o;

   spi_slave_sync #(.SYNC_STAGES(2), .FILL_BYTE(FILL)) dut (
      .sysClk_i   (sysClk_i),
      .reset_i    (reset_i),
      .spiClk_i   (spiClk_i),
      .ss_i_n     (ss_i_n),
      .mosi_i     (mosi_i),
      .miso_o     (miso_o),
      .tx_byte_i  (tx_byte_i),
      .tx_load_i  (tx_load_i),
      .tx_ready_o (tx_ready_o),
      .rx_byte_o  (rx_byte_o),
      .rx_valid_o (rx_valid_o),
      .busy_o     (busy_o),
      .abort_o    (abort_o)
   );

   always #5 sysClk_i = ~sysClk_i;

   int tests = 0;
   int fails = 0;

   // strobe monitor
   int         rx_cnt = 0;
   int         abort_cnt = 0;
   logic [7:0] rx_q[$];

   always @(negedge sysClk_i) begin
      if (!reset_i) begin
         if (rx_valid_o) begin
            rx_cnt++;
            rx_q.push_back(rx_byte_o);
         end
         if (abort_o)
            abort_cnt++;
      end
   end

   // frame description
   logic [7:0] f_mosi[4];
   bit         f_ld[4];
   logic [7:0] f_ldv[4];
   logic [7:0] f_miso[4];
   int         f_n;
   int         f_last_bits;
   bit         f_coinc;
   logic [7:0] f_coinc_val;

   // model state
   bit         m_full = 1'b0;
   logic [7:0] m_val = 8'h00;
   logic [7:0] m_rx_last = 8'h00;
   logic [7:0] m_exp[4];
   int         m_nfull;
   int         m_abort;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge sysClk_i);
      #1;
   endtask

   task automatic model_load(input logic [7:0] v);
      if (!m_full) begin
         m_full = 1'b1;
         m_val  = v;
      end
   endtask

   task automatic load_byte(input logic [7:0] v);
      tx_byte_i = v;
      tx_load_i = 1'b1;
      tick(1);
      tx_load_i = 1'b0;
      model_load(v);
   endtask

   // Each started byte takes the holding register (or FILL); a completed
   // final byte is followed by one more byte-boundary take on its last SCK fall.
   task automatic model_frame();
      int nb;
      m_nfull = (f_last_bits == 8) ? f_n : f_n - 1;
      m_abort = (f_last_bits == 8) ? 0 : 1;
      for (int b = 0; b < f_n; b++) begin
         nb = (b == f_n - 1) ? f_last_bits : 8;
         m_exp[b] = m_full ? m_val : FILL;
         m_full = 1'b0;
         if (b == 0 && f_coinc)
            model_load(f_coinc_val);
         if (f_ld[b] && nb >= 4)
            model_load(f_ldv[b]);
      end
      if (f_last_bits == 8)
         m_full = 1'b0;
      for (int b = 0; b < m_nfull; b++)
         m_rx_last = f_mosi[b];
   endtask

   task automatic do_frame();
      int nb;
      ss_i_n = 1'b0;
      if (f_coinc) begin
         tick(2);
         tx_byte_i = f_coinc_val;
         tx_load_i = 1'b1;
         tick(1);
         tx_load_i = 1'b0;
         tick(3);
      end else begin
         tick(6);
      end
      chk("busy_in_frame", 32'(busy_o), 32'd1);
      for (int b = 0; b < f_n; b++) begin
         nb = (b == f_n - 1) ? f_last_bits : 8;
         for (int i = 0; i < nb; i++) begin
            mosi_i = f_mosi[b][7-i];
            tick(4);
            spiClk_i = 1'b1;
            f_miso[b][7-i] = miso_o;
            if (i == 3 && f_ld[b]) begin
               tx_byte_i = f_ldv[b];
               tx_load_i = 1'b1;
               tick(1);
               tx_load_i = 1'b0;
               tick(3);
            end else begin
               tick(4);
            end
            spiClk_i = 1'b0;
         end
      end
      tick(4);
      ss_i_n = 1'b1;
      tick(8);
   endtask

   task automatic run_frame(input string tag);
      int rx0;
      int ab0;
      logic [7:0] got;
      rx0 = rx_cnt;
      ab0 = abort_cnt;
      model_frame();
      do_frame();
      for (int b = 0; b < m_nfull; b++) begin
         chk({tag, "_miso"}, 32'(f_miso[b]), 32'(m_exp[b]));
         if (rx_q.size() > 0) begin
            got = rx_q.pop_front();
            chk({tag, "_rx"}, 32'(got), 32'(f_mosi[b]));
         end
      end
      chk({tag, "_rx_count"}, 32'(rx_cnt - rx0), 32'(m_nfull));
      chk({tag, "_abort_count"}, 32'(abort_cnt - ab0), 32'(m_abort));
      chk({tag, "_rx_byte"}, 32'(rx_byte_o), 32'(m_rx_last));
      chk({tag, "_busy_end"}, 32'(busy_o), 32'd0);
      chk({tag, "_ready_end"}, 32'(tx_ready_o), 32'(!m_full));
      rx_q.delete();
   endtask

   task automatic clear_frame();
      for (int b = 0; b < 4; b++) begin
         f_mosi[b] = 8'h00;
         f_ld[b]   = 1'b0;
         f_ldv[b]  = 8'h00;
      end
      f_n = 1;
      f_last_bits = 8;
      f_coinc = 1'b0;
      f_coinc_val = 8'h00;
   endtask

   typedef struct {
      bit         load;
      logic [7:0] tx;
      logic [7:0] mosi;
      logic [7:0] exp_miso;
   } vec_t;

   vec_t tbl[4];

   initial begin
      tbl[0] = '{load: 1'b1, tx: 8'hA5, mosi: 8'h3C, exp_miso: 8'hA5};
      tbl[1] = '{load: 1'b0, tx: 8'h00, mosi: 8'h81, exp_miso: FILL};
      tbl[2] = '{load: 1'b1, tx: 8'hFF, mosi: 8'h00, exp_miso: 8'hFF};
      tbl[3] = '{load: 1'b1, tx: 8'h01, mosi: 8'h80, exp_miso: 8'h01};

      reset_i = 1'b1;
      spiClk_i = 1'b0;
      ss_i_n = 1'b1;
      mosi_i = 1'b0;
      tx_byte_i = 8'h00;
      tx_load_i = 1'b0;
      clear_frame();
      tick(3);

      // reset held with SS low and SCK toggling
      ss_i_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         spiClk_i = ~spiClk_i;
         mosi_i = 1'b1;
         tick(1);
      end
      spiClk_i = 1'b0;
      chk("rst_miso", 32'(miso_o), 32'd0);
      chk("rst_ready", 32'(tx_ready_o), 32'd1);
      chk("rst_rx_byte", 32'(rx_byte_o), 32'h00);
      chk("rst_rx_valid", 32'(rx_valid_o), 32'd0);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_abort", 32'(abort_o), 32'd0);

      // released inside a frame: must not join it
      reset_i = 1'b0;
      tick(2);
      for (int i = 0; i < 10; i++) begin
         mosi_i = i[0];
         tick(4);
         spiClk_i = 1'b1;
         tick(4);
         spiClk_i = 1'b0;
      end
      tick(4);
      chk("no_join_rx", 32'(rx_cnt), 32'd0);
      chk("no_join_busy", 32'(busy_o), 32'd0);
      chk("no_join_abort", 32'(abort_cnt), 32'd0);
      ss_i_n = 1'b1;
      tick(8);
      rx_q.delete();

      // single-byte table
      for (int t = 0; t < 4; t++) begin
         clear_frame();
         if (tbl[t].load) begin
            load_byte(tbl[t].tx);
            chk("tbl_ready_after_load", 32'(tx_ready_o), 32'd0);
         end
         f_mosi[0] = tbl[t].mosi;
         run_frame("tbl");
         chk("tbl_exp_miso", 32'(f_miso[0]), 32'(tbl[t].exp_miso));
      end

      // two-byte burst, second byte loaded mid-first-byte
      clear_frame();
      load_byte(8'h11);
      f_n = 2;
      f_mosi[0] = 8'hF0;
      f_mosi[1] = 8'h0F;
      f_ld[0] = 1'b1;
      f_ldv[0] = 8'h22;
      run_frame("burst");
      chk("burst_b0", 32'(f_miso[0]), 32'h11);
      chk("burst_b1", 32'(f_miso[1]), 32'h22);

      // abort after 5 SCK rising edges, then a clean frame
      clear_frame();
      f_mosi[0] = 8'hC3;
      f_last_bits = 5;
      run_frame("abort");
      chk("abort_keeps_rx", 32'(rx_byte_o), 32'h0F);
      clear_frame();
      f_mosi[0] = 8'h5A;
      run_frame("after_abort");
      chk("after_abort_rx", 32'(rx_byte_o), 32'h5A);

      // load while full is ignored
      clear_frame();
      load_byte(8'h99);
      load_byte(8'h77);
      chk("ignored_ready", 32'(tx_ready_o), 32'd0);
      f_mosi[0] = 8'h3E;
      run_frame("ignored");
      chk("ignored_sent", 32'(f_miso[0]), 32'h99);

      // load coincident with frame start while empty
      clear_frame();
      f_n = 2;
      f_mosi[0] = 8'h12;
      f_mosi[1] = 8'h34;
      f_coinc = 1'b1;
      f_coinc_val = 8'h77;
      run_frame("coinc");
      chk("coinc_b0", 32'(f_miso[0]), 32'(FILL));
      chk("coinc_b1", 32'(f_miso[1]), 32'h77);

      // randomized frames
      for (int r = 0; r < 16; r++) begin
         clear_frame();
         if ($urandom_range(0, 1) == 1)
            load_byte(8'($urandom));
         f_n = $urandom_range(1, 3);
         f_last_bits = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 8;
         f_coinc = ($urandom_range(0, 4) == 0);
         f_coinc_val = 8'($urandom);
         for (int b = 0; b < 4; b++) begin
            f_mosi[b] = 8'($urandom);
            f_ld[b]   = ($urandom_range(0, 1) == 1);
            f_ldv[b]  = 8'($urandom);
         end
         run_frame("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
